// File: rtl/sharpen_pixel_ctrl.sv
// Sharpen pixel controller: fetches C/N/S/W/E taps through an external tap counter,
// accumulates 5*C - N - S - W - E, clamps to the pixel range and writes the result.
module sharpen_pixel_ctrl #(
    parameter int ADDR_W = 16,
    parameter int IMG_W  = 64,
    parameter int PIX_W  = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] SRC_ADDR,
    input  logic [ADDR_W-1:0] DST_ADDR,
    input  logic [4:0]        CNT,
    output logic              CNT_CE,
    output logic              CNT_RST,
    output logic              RD_REQ,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic              RD_ACK,
    input  logic [PIX_W-1:0]  RD_DATA,
    output logic              WR_REQ,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [PIX_W-1:0]  WR_DATA,
    input  logic              WR_ACK,
    output logic [PIX_W-1:0]  RESULT,
    output logic              BUSY,
    output logic              DONE
);

    // state | meaning
    // IDLE  | waiting for START
    // CLR   | tap counter being cleared
    // FETCH | read request for tap CNT outstanding
    // GAP   | request dropped while the counter advances
    // SAT   | clamp accumulator into RESULT
    // WRITE | write request outstanding

    localparam int ACC_W = PIX_W + 4;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FETCH,
        S_GAP,
        S_SAT,
        S_WRITE
    } state_t;

    state_t state_q, state_nx;

    logic [ADDR_W-1:0]       src_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] pix_ext;
    logic [PIX_W-1:0]        sat_val;

    logic              cnt_ce_d, cnt_rst_d, rd_req_d, wr_req_d, busy_d, done_d;
    logic [ADDR_W-1:0] rd_addr_d;

    function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] c,
                                                    input logic [2:0] idx);
        case (idx)
            3'd1:    tap_addr = c - ADDR_W'(IMG_W);
            3'd2:    tap_addr = c + ADDR_W'(IMG_W);
            3'd3:    tap_addr = c - ADDR_W'(1);
            3'd4:    tap_addr = c + ADDR_W'(1);
            default: tap_addr = c;
        endcase
    endfunction

    assign pix_ext = $signed(ACC_W'(RD_DATA));

    always_comb begin
        if (acc_q[ACC_W-1])
            sat_val = '0;
        else if (acc_q > PIX_MAX)
            sat_val = '1;
        else
            sat_val = acc_q[PIX_W-1:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            acc_q   <= '0;
            CNT_CE  <= 1'b0;
            CNT_RST <= 1'b0;
            RD_REQ  <= 1'b0;
            RD_ADDR <= '0;
            WR_REQ  <= 1'b0;
            WR_ADDR <= '0;
            WR_DATA <= '0;
            RESULT  <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state_q <= state_nx;
            CNT_CE  <= cnt_ce_d;
            CNT_RST <= cnt_rst_d;
            RD_REQ  <= rd_req_d;
            RD_ADDR <= rd_addr_d;
            WR_REQ  <= wr_req_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
            if (state_q == S_IDLE && START) begin
                src_q   <= SRC_ADDR;
                WR_ADDR <= DST_ADDR;
                acc_q   <= '0;
            end
            if (state_q == S_FETCH && RD_ACK) begin
                if (CNT == 5'd0)
                    acc_q <= acc_q + (pix_ext <<< 2) + pix_ext;
                else
                    acc_q <= acc_q - pix_ext;
            end
            if (state_q == S_SAT) begin
                RESULT  <= sat_val;
                WR_DATA <= sat_val;
            end
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_IDLE:  if (START) state_nx = S_CLR;
            S_CLR:   state_nx = S_FETCH;
            S_FETCH: if (RD_ACK) state_nx = (CNT == 5'd4) ? S_SAT : S_GAP;
            S_GAP:   state_nx = S_FETCH;
            S_SAT:   state_nx = S_WRITE;
            S_WRITE: if (WR_ACK) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered, so each one is computed for the state being entered.
    // Leaving GAP the counter steps on this edge, hence the next tap is CNT+1.
    always_comb begin
        cnt_ce_d  = 1'b0;
        cnt_rst_d = 1'b0;
        rd_req_d  = 1'b0;
        rd_addr_d = RD_ADDR;
        wr_req_d  = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_nx != S_IDLE);
        case (state_q)
            S_IDLE:  cnt_rst_d = START;
            S_CLR: begin
                rd_req_d  = 1'b1;
                rd_addr_d = tap_addr(src_q, 3'd0);
            end
            S_FETCH: begin
                cnt_ce_d = RD_ACK;
                rd_req_d = !RD_ACK;
            end
            S_GAP: begin
                rd_req_d  = 1'b1;
                rd_addr_d = tap_addr(src_q, CNT[2:0] + 3'd1);
            end
            S_SAT:   wr_req_d = 1'b1;
            S_WRITE: begin
                wr_req_d = !WR_ACK;
                done_d   = WR_ACK;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sharpen_pixel_ctrl.sv
// Testbench for sharpen_pixel_ctrl: external tap counter and image memory are modelled here,
// expected results come from the kernel arithmetic on the taps written into memory.
module tb_sharpen_pixel_ctrl;

    logic        CLK      = 1'b0;
    logic        RST_N    = 1'b0;
    logic        START    = 1'b0;
    logic [15:0] SRC_ADDR = '0;
    logic [15:0] DST_ADDR = '0;
    logic [4:0]  CNT;
    logic        CNT_CE;
    logic        CNT_RST;
    logic        RD_REQ;
    logic [15:0] RD_ADDR;
    logic        RD_ACK   = 1'b0;
    logic [7:0]  RD_DATA  = '0;
    logic        WR_REQ;
    logic [15:0] WR_ADDR;
    logic [7:0]  WR_DATA;
    logic        WR_ACK   = 1'b0;
    logic [7:0]  RESULT;
    logic        BUSY;
    logic        DONE;

    int n_cmp = 0;
    int n_err = 0;

    sharpen_pixel_ctrl #(.ADDR_W(16), .IMG_W(64), .PIX_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .CNT(CNT),
        .CNT_CE(CNT_CE), .CNT_RST(CNT_RST),
        .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_ACK(RD_ACK), .RD_DATA(RD_DATA),
        .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_ACK(WR_ACK),
        .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // External tap counter: synchronous clear has priority over enable, no link to RST_N.
    logic [4:0] cnt_q = 5'd9;
    assign CNT = cnt_q;
    always @(posedge CLK) begin
        if (CNT_RST) cnt_q <= 5'd0;
        else if (CNT_CE) cnt_q <= cnt_q + 5'd1;
    end

    logic [7:0] mem [logic [15:0]];

    logic [15:0] o_rd [$];
    int          o_ce, o_rst, o_done, o_unstable, o_busy_low;
    logic [7:0]  o_result, o_wr_data;
    logic [15:0] o_wr_addr;
    bit          o_aborted;

    function automatic logic [15:0] tap_addr(input logic [15:0] src, input int k);
        int off [5] = '{0, -64, 64, -1, 1};
        return 16'(int'(src) + off[k]);
    endfunction

    function automatic int ref_pix(input int c, n, s, w, e);
        int v = 5 * c - n - s - w - e;
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    task automatic set_taps(input logic [15:0] src, input int c, n, s, w, e);
        mem[tap_addr(src, 0)] = 8'(c);
        mem[tap_addr(src, 1)] = 8'(n);
        mem[tap_addr(src, 2)] = 8'(s);
        mem[tap_addr(src, 3)] = 8'(w);
        mem[tap_addr(src, 4)] = 8'(e);
    endtask

    // Issues one command and plays the memory side; records what the DUT did.
    task automatic run_cmd(input logic [15:0] src, dst, input int rd_dly, wr_dly,
                           input int restart_at, abort_cnt, input bit spur);
        int          rd_wait = 0;
        int          wr_wait = 0;
        bit          prev_req = 0;
        logic [15:0] prev_addr = '0;
        o_rd.delete();
        o_ce = 0; o_rst = 0; o_done = -1; o_unstable = 0; o_busy_low = 0; o_aborted = 0;
        o_result = 'x; o_wr_data = 'x; o_wr_addr = 'x;
        @(negedge CLK);
        SRC_ADDR = src; DST_ADDR = dst; START = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge CLK);
            @(negedge CLK);
            START = (cyc == restart_at);
            SRC_ADDR = 16'($urandom);
            DST_ADDR = 16'($urandom);
            if (CNT_CE) o_ce++;
            if (CNT_RST) o_rst++;
            if (RD_REQ && prev_req && RD_ADDR !== prev_addr) o_unstable++;
            prev_req = RD_REQ; prev_addr = RD_ADDR;
            if (DONE) begin
                o_done = cyc; o_result = RESULT;
                break;
            end
            if (!BUSY) o_busy_low++;
            if (abort_cnt >= 0 && RD_REQ && CNT == 5'(abort_cnt)) begin
                RST_N = 1'b0; o_aborted = 1;
                break;
            end
            if (RD_REQ) begin
                if (rd_wait == rd_dly) begin
                    RD_ACK = 1'b1;
                    RD_DATA = mem.exists(RD_ADDR) ? mem[RD_ADDR] : 8'h00;
                    o_rd.push_back(RD_ADDR);
                    rd_wait = 0;
                end else begin
                    RD_ACK = 1'b0; rd_wait++;
                end
            end else begin
                RD_ACK = spur ? 1'($urandom) : 1'b0;
                RD_DATA = 8'($urandom);
            end
            if (WR_REQ) begin
                if (wr_wait == wr_dly) begin
                    WR_ACK = 1'b1; o_wr_data = WR_DATA; o_wr_addr = WR_ADDR; wr_wait = 0;
                end else begin
                    WR_ACK = 1'b0; wr_wait++;
                end
            end else begin
                WR_ACK = spur ? 1'($urandom) : 1'b0;
            end
        end
        START = 1'b0; RD_ACK = 1'b0; WR_ACK = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if ({BUSY, DONE, RD_REQ, WR_REQ, CNT_CE, CNT_RST} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 000000", {BUSY, DONE, RD_REQ, WR_REQ, CNT_CE, CNT_RST});
        end
        n_cmp++;
        if ({RD_ADDR, WR_ADDR, WR_DATA, RESULT} !== 48'h0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {RD_ADDR, WR_ADDR, WR_DATA, RESULT});
        end
        RST_N = 1'b1;
    endtask

    task automatic test_uniform();
        set_taps(16'h0100, 100, 100, 100, 100, 100);
        run_cmd(16'h0100, 16'h2000, 0, 0, -1, -1, 0);
        n_cmp++;
        if (o_rd.size() != 5) begin n_err++; $display("FAIL t1_reads: got %0d want 5", o_rd.size()); end
        for (int k = 0; k < 5 && k < o_rd.size(); k++) begin
            n_cmp++;
            if (o_rd[k] !== tap_addr(16'h0100, k)) begin
                n_err++; $display("FAIL t1_rd_addr[%0d]: got %h want %h", k, o_rd[k], tap_addr(16'h0100, k));
            end
        end
        n_cmp++;
        if (o_result !== 8'd100) begin n_err++; $display("FAIL t1_result: got %0d want 100", o_result); end
        n_cmp++;
        if (o_wr_addr !== 16'h2000) begin n_err++; $display("FAIL t1_wr_addr: got %h want 2000", o_wr_addr); end
        n_cmp++;
        if (o_done != 13) begin n_err++; $display("FAIL t1_done_cycle: got %0d want 13", o_done); end
        n_cmp++;
        if (o_ce != 5 || o_rst != 1) begin
            n_err++; $display("FAIL t1_counter: got ce=%0d rst=%0d want ce=5 rst=1", o_ce, o_rst);
        end
    endtask

    task automatic test_mixed();
        set_taps(16'h3000, 120, 100, 110, 90, 130);
        run_cmd(16'h3000, 16'h4000, 0, 0, -1, -1, 1);
        n_cmp++;
        if (o_wr_data !== 8'd170) begin n_err++; $display("FAIL t2_wr_data: got %0d want 170", o_wr_data); end
        n_cmp++;
        if (o_result !== 8'd170) begin n_err++; $display("FAIL t2_result: got %0d want 170", o_result); end
    endtask

    task automatic test_clamp();
        set_taps(16'h1234, 200, 50, 50, 50, 50);
        run_cmd(16'h1234, 16'h5555, 0, 1, -1, -1, 1);
        n_cmp++;
        if (o_wr_data !== 8'(ref_pix(200, 50, 50, 50, 50))) begin
            n_err++; $display("FAIL t3_clamp_hi: got %0d want 255", o_wr_data);
        end
        n_cmp++;
        if (o_done != 14) begin n_err++; $display("FAIL t3_done_wr_wait: got %0d want 14", o_done); end
        set_taps(16'h0800, 10, 60, 60, 60, 60);
        run_cmd(16'h0800, 16'h5556, 0, 0, -1, -1, 1);
        n_cmp++;
        if (o_result !== 8'd0) begin n_err++; $display("FAIL t3_clamp_lo: got %0d want 0", o_result); end
    endtask

    task automatic test_wait_and_restart();
        set_taps(16'h6040, 120, 100, 110, 90, 130);
        run_cmd(16'h6040, 16'h7000, 3, 0, 5, -1, 1);
        n_cmp++;
        if (o_unstable != 0) begin n_err++; $display("FAIL t4_req_stable: got %0d changes want 0", o_unstable); end
        n_cmp++;
        if (o_ce != 5 || o_rst != 1) begin
            n_err++; $display("FAIL t4_counter: got ce=%0d rst=%0d want ce=5 rst=1", o_ce, o_rst);
        end
        n_cmp++;
        if (o_result !== 8'd170) begin n_err++; $display("FAIL t4_result: got %0d want 170", o_result); end
        n_cmp++;
        if (o_done != 28 || o_busy_low != 0) begin
            n_err++; $display("FAIL t4_timing: got done=%0d busy_low=%0d want 28/0", o_done, o_busy_low);
        end
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (BUSY !== 1'b0 || CNT_RST !== 1'b0) begin
            n_err++; $display("FAIL t4_not_queued: got busy=%b cnt_rst=%b want 0/0", BUSY, CNT_RST);
        end
    endtask

    task automatic test_reset_midfetch();
        set_taps(16'h2222, 30, 10, 20, 5, 15);
        run_cmd(16'h2222, 16'h0010, 1, 0, -1, 2, 0);
        #1;
        n_cmp++;
        if (!o_aborted || {BUSY, DONE, RD_REQ, WR_REQ, CNT_CE, CNT_RST, RD_ADDR, WR_ADDR, WR_DATA, RESULT} !== 54'h0) begin
            n_err++; $display("FAIL t5_abort_outputs: got aborted=%0d outs=%h want 1/0", o_aborted,
                              {BUSY, DONE, RD_REQ, WR_REQ, CNT_CE, CNT_RST, RD_ADDR, WR_ADDR, WR_DATA, RESULT});
        end
        @(negedge CLK);
        RST_N = 1'b1;
        run_cmd(16'h2222, 16'h0010, 0, 0, -1, -1, 0);
        n_cmp++;
        if (o_rst != 1 || o_rd.size() != 5 || o_rd[0] !== 16'h2222) begin
            n_err++; $display("FAIL t5_refetch: got rst=%0d reads=%0d first=%h want 1/5/2222",
                              o_rst, o_rd.size(), (o_rd.size() > 0) ? o_rd[0] : 16'h0);
        end
        n_cmp++;
        if (o_result !== 8'(ref_pix(30, 10, 20, 5, 15))) begin
            n_err++; $display("FAIL t5_result: got %0d want %0d", o_result, ref_pix(30, 10, 20, 5, 15));
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [15:0] src = 16'($urandom);
            logic [15:0] dst = 16'($urandom);
            int v [5];
            int rd_dly = $urandom_range(0, 2);
            int wr_dly = $urandom_range(0, 2);
            int exp_pix;
            for (int k = 0; k < 5; k++) v[k] = $urandom_range(0, 255);
            if (it == 0) v[0] = 255;
            set_taps(src, v[0], v[1], v[2], v[3], v[4]);
            exp_pix = ref_pix(v[0], v[1], v[2], v[3], v[4]);
            run_cmd(src, dst, rd_dly, wr_dly, -1, -1, 1);
            n_cmp++;
            if (o_wr_data !== 8'(exp_pix) || o_wr_addr !== dst) begin
                n_err++; $display("FAIL rand%0d_write: got %0d@%h want %0d@%h", it, o_wr_data, o_wr_addr, exp_pix, dst);
            end
            n_cmp++;
            if (o_done != 13 + 5 * rd_dly + wr_dly || o_ce != 5) begin
                n_err++; $display("FAIL rand%0d_timing: got done=%0d ce=%0d want %0d/5", it, o_done, o_ce,
                                  13 + 5 * rd_dly + wr_dly);
            end
            for (int k = 0; k < 5 && k < o_rd.size(); k++) begin
                n_cmp++;
                if (o_rd[k] !== tap_addr(src, k)) begin
                    n_err++; $display("FAIL rand%0d_rd_addr[%0d]: got %h want %h", it, k, o_rd[k], tap_addr(src, k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_mixed();
        test_clamp();
        test_wait_and_restart();
        test_reset_midfetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
